fetch_queue: RTL and testbench



---
 rtl/fetch_pkg.sv | 19 +
 rtl/sync_fifo.sv | 62 ++++++
 rtl/fetch_queue.sv | 99 +++++++++
 tb/tb_fetch_queue.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage: FSM state encoding, reset PC default and
// the {pc, instr} entry layout buffered between fetch and decode.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    MISS  = 2'd1,
    FULL  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          ENTRY_W          = 64;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Small circular FIFO with push/pop/flush and occupancy count. The head entry
// is shown combinationally and reads as zero when the FIFO is empty.
module sync_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = ENTRY_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int             AW      = $clog2(DEPTH);
  localparam logic [AW:0]    DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_count;
  logic             w_doPop;
  logic             w_doPush;

  // A pop frees the slot the push needs, so push+pop is legal when full.
  assign w_doPop  = i_pop & (r_count != '0);
  assign w_doPush = i_push & ((r_count != DEPTH_C) | w_doPop);

  always_ff @(posedge clk) begin
    if (w_doPush && !i_flush) begin
      r_mem[r_wrPtr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = (r_count != '0) ? r_mem[r_rdPtr] : '0;
  assign o_count = r_count;

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: owns the PC, captures instruction words on hit into a small
// FIFO feeding decode, handles redirect flushes and counts miss cycles.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          PC_STEP  = 1,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  output logic [31:0]      PC,
  input  logic             hit,
  input  logic [31:0]      instr2Word,
  input  logic             redirectValid,
  input  logic [31:0]      redirectPC,
  output logic             outValid,
  input  logic             outReady,
  output logic [31:0]      outInstr,
  output logic [31:0]      outPC,
  output logic [CNT_W-1:0] missCount
);

  localparam int           CW       = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fetch_state_e     r_state;
  logic [31:0]      r_pc;
  logic [CNT_W-1:0] r_missCount;

  logic [CW-1:0]    w_count;
  logic             w_pop;
  logic             w_space;
  logic             w_push;
  fetch_entry_t     w_wrEntry;
  fetch_entry_t     w_rdEntry;

  assign outValid = (w_count != '0);
  assign w_pop    = outValid & outReady;
  assign w_space  = (w_count < FULL_CNT) | w_pop;
  assign w_push   = hit & w_space & ~redirectValid &
                    ((r_state == FETCH) | (r_state == MISS));

  assign w_wrEntry = '{pc: r_pc, instr: instr2Word};

  // Redirect flushes the queue, which also discards any same-cycle pop.
  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirectValid),
    .i_wdata (w_wrEntry),
    .o_rdata (w_rdEntry),
    .o_count (w_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= FETCH;
      r_pc        <= RESET_PC;
      r_missCount <= '0;
    end else begin
      if ((r_state == MISS) && (r_missCount != '1)) begin
        r_missCount <= r_missCount + CNT_W'(1);
      end
      if (redirectValid) begin
        r_pc    <= redirectPC;
        r_state <= FETCH;
      end else begin
        if (w_push) r_pc <= r_pc + 32'(PC_STEP);
        case (r_state)
          FETCH: begin
            if (!hit && w_space) r_state <= MISS;
            else if (!w_space)   r_state <= FULL;
          end
          MISS: begin
            if (hit && w_space) r_state <= FETCH;
          end
          FULL: begin
            // The pop cycle only frees a slot; fetching resumes next cycle.
            if (w_pop) r_state <= FETCH;
          end
          default: r_state <= FETCH;
        endcase
      end
    end
  end

  assign PC        = r_pc;
  assign missCount = r_missCount;
  assign outPC     = w_rdEntry.pc;
  assign outInstr  = w_rdEntry.instr;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector tables, an async-reset sequence and a
// randomized run against a queue-based reference model.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC;
  logic        hit;
  logic [31:0] instr2Word;
  logic        redirectValid;
  logic [31:0] redirectPC;
  logic        outValid;
  logic        outReady;
  logic [31:0] outInstr;
  logic [31:0] outPC;
  logic [15:0] missCount;

  int nCompared   = 0;
  int nMismatched = 0;

  typedef struct {
    logic        hit;
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        eValid;
    logic [31:0] eOutPC;
    logic [31:0] ePC;
    logic [15:0] eMiss;
  } vec_t;

  vec_t tableA[$];
  vec_t tableB[$];

  // Reference model state: queued {pc,instr} pairs, PC, miss counter, mode.
  logic [63:0] mQ[$];
  logic [31:0] mPC;
  logic [15:0] mMiss;
  logic        mInMiss;
  logic        mInFull;

  always #5 clk = ~clk;

  fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (1),
    .CNT_W    (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .PC            (PC),
    .hit           (hit),
    .instr2Word    (instr2Word),
    .redirectValid (redirectValid),
    .redirectPC    (redirectPC),
    .outValid      (outValid),
    .outReady      (outReady),
    .outInstr      (outInstr),
    .outPC         (outPC),
    .missCount     (missCount)
  );

  // Instruction memory stand-in: a fixed scramble of the address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign instr2Word = memWord(PC);

  task automatic compareField(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic eValid,
                             input logic [31:0] eOutPC, input logic [31:0] eInstr,
                             input logic [31:0] ePC, input logic [15:0] eMiss);
    compareField({tag, ".outValid"}, {31'b0, outValid}, {31'b0, eValid});
    compareField({tag, ".outPC"}, outPC, eOutPC);
    compareField({tag, ".outInstr"}, outInstr, eInstr);
    compareField({tag, ".PC"}, PC, ePC);
    compareField({tag, ".missCount"}, {16'b0, missCount}, {16'b0, eMiss});
  endtask

  task automatic applyStimulus(input logic h, input logic r, input logic rd,
                               input logic [31:0] rp);
    hit           = h;
    outReady      = r;
    redirectValid = rd;
    redirectPC    = rp;
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic vec_t mk(input logic h, input logic r, input logic rd,
                              input logic [31:0] rp, input logic v,
                              input logic [31:0] op, input logic [31:0] p,
                              input logic [15:0] m);
    vec_t t;
    t.hit = h; t.ready = r; t.redir = rd; t.rpc = rp;
    t.eValid = v; t.eOutPC = op; t.ePC = p; t.eMiss = m;
    return t;
  endfunction

  task automatic runTable(input string name, input vec_t tbl[$]);
    foreach (tbl[i]) begin
      checkOutput($sformatf("%s[%0d]", name, i), tbl[i].eValid, tbl[i].eOutPC,
                  tbl[i].eValid ? memWord(tbl[i].eOutPC) : 32'h0,
                  tbl[i].ePC, tbl[i].eMiss);
      applyStimulus(tbl[i].hit, tbl[i].ready, tbl[i].redir, tbl[i].rpc);
      @(negedge clk);
    end
  endtask

  function automatic void modelReset();
    mQ.delete();
    mPC     = 32'h0;
    mMiss   = 16'h0;
    mInMiss = 1'b0;
    mInFull = 1'b0;
  endfunction

  // One clock of the reference model, using the inputs currently driven.
  function automatic void modelStep();
    logic pop, space, push;
    pop   = (mQ.size() != 0) && outReady;
    space = (mQ.size() < DEPTH) || pop;
    if (mInMiss && mMiss != 16'hFFFF) mMiss = mMiss + 16'd1;
    if (redirectValid) begin
      mQ.delete();
      mPC     = redirectPC;
      mInMiss = 1'b0;
      mInFull = 1'b0;
    end else begin
      push = hit && space && !mInFull;
      if (pop) void'(mQ.pop_front());
      if (push) begin
        mQ.push_back({mPC, memWord(mPC)});
        mPC = mPC + 32'd1;
      end
      if (mInFull)           mInFull = !pop;
      else if (mInMiss)      mInMiss = !(hit && space);
      else if (!hit && space) mInMiss = 1'b1;
      else if (!space)       mInFull = 1'b1;
    end
  endfunction

  initial begin
    // Steady fetch, a 3-cycle miss at PC 2, fill to full, redirects incl. PC wrap.
    tableA.push_back(mk(1,1,0,0,           0,0,0,0));
    tableA.push_back(mk(1,1,0,0,           1,0,1,0));
    tableA.push_back(mk(0,1,0,0,           1,1,2,0));
    tableA.push_back(mk(0,1,0,0,           0,0,2,0));
    tableA.push_back(mk(0,1,0,0,           0,0,2,1));
    tableA.push_back(mk(1,0,0,0,           0,0,2,2));
    tableA.push_back(mk(1,0,0,0,           1,2,3,3));
    tableA.push_back(mk(1,0,0,0,           1,2,4,3));
    tableA.push_back(mk(1,0,0,0,           1,2,5,3));
    tableA.push_back(mk(1,0,0,0,           1,2,6,3));
    tableA.push_back(mk(1,1,0,0,           1,2,6,3));
    tableA.push_back(mk(1,1,0,0,           1,3,6,3));
    tableA.push_back(mk(1,1,1,32'h40,      1,4,7,3));
    tableA.push_back(mk(1,1,0,0,           0,0,32'h40,3));
    tableA.push_back(mk(1,0,1,32'hFFFF_FFFF,1,32'h40,32'h41,3));
    tableA.push_back(mk(1,0,0,0,           0,0,32'hFFFF_FFFF,3));
    tableA.push_back(mk(1,0,0,0,           1,32'hFFFF_FFFF,0,3));
    tableA.push_back(mk(0,0,0,0,           1,32'hFFFF_FFFF,1,3));

    // Fill to four, push+pop while full, FULL stall, then drain in order.
    tableB.push_back(mk(1,0,0,0, 0,0,0,0));
    tableB.push_back(mk(1,0,0,0, 1,0,1,0));
    tableB.push_back(mk(1,0,0,0, 1,0,2,0));
    tableB.push_back(mk(1,0,0,0, 1,0,3,0));
    tableB.push_back(mk(1,1,0,0, 1,0,4,0));
    tableB.push_back(mk(1,0,0,0, 1,1,5,0));
    tableB.push_back(mk(1,0,0,0, 1,1,5,0));
    tableB.push_back(mk(0,1,0,0, 1,1,5,0));
    tableB.push_back(mk(0,1,0,0, 1,2,5,0));
    tableB.push_back(mk(0,1,0,0, 1,3,5,0));
    tableB.push_back(mk(0,1,0,0, 1,4,5,1));
    tableB.push_back(mk(0,0,0,0, 0,0,5,2));
    tableB.push_back(mk(0,0,0,0, 0,0,5,3));

    doReset();
    runTable("seqA", tableA);

    // Two entries queued; assert reset between edges and look right away.
    checkOutput("preRst", 1'b1, 32'hFFFF_FFFF, memWord(32'hFFFF_FFFF), 32'h1, 16'd3);
    #2 reset = 1'b1;
    #1 checkOutput("asyncRst", 1'b0, 32'h0, 32'h0, 32'h0, 16'd0);
    @(negedge clk);
    reset = 1'b0;

    runTable("seqB", tableB);

    doReset();
    modelReset();
    for (int c = 0; c < 3000; c++) begin
      checkOutput($sformatf("rand[%0d]", c), mQ.size() != 0,
                  (mQ.size() != 0) ? mQ[0][63:32] : 32'h0,
                  (mQ.size() != 0) ? mQ[0][31:0]  : 32'h0, mPC, mMiss);
      applyStimulus($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 65,
                    $urandom_range(0, 99) < 5,
                    ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom());
      modelStep();
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
